attention_fp_ctrl: RTL and testbench

//  Sequencer for the MX floating-point attention datapath (Q*K^T matmul, per-row softmax, softmax*V matmul).

---
 rtl/attention_fp_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_attention_fp_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/attention_fp_ctrl.sv
// ---------------------------------------------------------------------------
// attention_fp_ctrl
//   Sequencer for the MX floating-point attention datapath. Each pass is
//   started by i_start and runs in this order:
//     1. Q*K^T matmul (MM1) for a fixed settle latency.
//     2. Stream S_KV score columns into the row softmax units, with handshake.
//     3. Count and index the softmax results into the capture registers.
//     4. softmax*V matmul (MM2) for a fixed settle latency.
//     5. A one-cycle o_done pulse.
//   i_abort drops the pass and returns to IDLE from any busy state.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_start          start a pass; only looked at in IDLE
//   i_abort          abandon the current pass
//   o_busy           high in every state except IDLE
//   o_mm1_en         MM1 operand/compute enable
//   o_col_idx        score column currently offered to softmax
//   o_sm_valid       softmax input valid
//   i_sm_ready       softmax input ready (AND over all rows)
//   i_sm_out_valid   softmax result valid (row 0; rows run in lockstep)
//   o_cap_en         write soft_res/soft_scale this cycle
//   o_cap_idx        soft_res column to write
//   o_scale_blk      soft_scale block to write (o_cap_idx >> log2(K))
//   o_mm2_en         MM2 operand/compute enable
//   o_done           one-cycle pulse, R_o/S_R_o valid
// ---------------------------------------------------------------------------
module attention_fp_ctrl #(
  parameter int S_KV    = 4,
  parameter int K       = 2,
  parameter int MM1_LAT = 3,
  parameter int MM2_LAT = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_mm1_en,
  output logic [$clog2(S_KV)-1:0] o_col_idx,
  output logic                    o_sm_valid,
  input  logic                    i_sm_ready,
  input  logic                    i_sm_out_valid,
  output logic                    o_cap_en,
  output logic [$clog2(S_KV)-1:0] o_cap_idx,
  output logic [$clog2(S_KV)-1:0] o_scale_blk,
  output logic                    o_mm2_en,
  output logic                    o_done
);

  localparam int IDX_W   = $clog2(S_KV);
  localparam int BLK_SH  = $clog2(K);
  localparam int LAT_MAX = (MM1_LAT > MM2_LAT) ? MM1_LAT : MM2_LAT;
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MM1   = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    MM2   = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [IDX_W-1:0]   col_q, col_d;
  // One bit wider than a column index so "all S_KV results captured" is
  // representable without wrapping back to column 0.
  logic [IDX_W:0]     out_q, out_d;
  logic               busy_q, mm1_q, smv_q, mm2_q, done_q;
  logic               cap_en;
  logic               in_xfer;

  // Next-state and counter logic. Input and output handshakes are handled
  // independently so a softmax result may be captured in the same cycle a
  // new column is accepted. Abort is applied last so it overrides everything.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    col_d   = col_q;
    out_d   = out_q;
    cap_en  = 1'b0;
    in_xfer = (state_q == FEED) && i_sm_ready;

    // Results beyond the S_KV-th are dropped so the capture array is never
    // overwritten by a stray valid.
    if (((state_q == FEED) || (state_q == DRAIN)) && i_sm_out_valid &&
        (out_q < (IDX_W+1)'(S_KV))) begin
      cap_en = 1'b1;
      out_d  = out_q + (IDX_W+1)'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = MM1;
          lat_d   = LAT_W'(MM1_LAT - 1);
        end
      end
      MM1: begin
        if (lat_q == '0) begin
          state_d = FEED;
          col_d   = '0;
          out_d   = '0;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      FEED: begin
        if (in_xfer) begin
          if (col_q == IDX_W'(S_KV - 1)) begin
            state_d = DRAIN;
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        // Leaves on the cycle the last result is captured, or straight away
        // if every result already arrived while still feeding.
        if (out_d == (IDX_W+1)'(S_KV)) begin
          state_d = MM2;
          lat_d   = LAT_W'(MM2_LAT - 1);
        end
      end
      MM2: begin
        if (lat_q == '0) begin
          state_d = DONE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        col_d   = '0;
        out_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (i_abort && (state_q != IDLE)) begin
      state_d = IDLE;
      lat_d   = '0;
      col_d   = '0;
      out_d   = '0;
    end
  end

  // State, counters and the registered control outputs. The outputs are
  // decoded from the next state so they line up exactly with the state
  // register while still coming straight from flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      col_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      mm1_q   <= 1'b0;
      smv_q   <= 1'b0;
      mm2_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      col_q   <= col_d;
      out_q   <= out_d;
      busy_q  <= (state_d != IDLE);
      mm1_q   <= (state_d == MM1);
      smv_q   <= (state_d == FEED);
      mm2_q   <= (state_d == MM2);
      done_q  <= (state_d == DONE);
    end
  end

  assign o_busy      = busy_q;
  assign o_mm1_en    = mm1_q;
  assign o_sm_valid  = smv_q;
  assign o_mm2_en    = mm2_q;
  assign o_done      = done_q;
  assign o_col_idx   = col_q;
  assign o_cap_en    = cap_en;
  assign o_cap_idx   = out_q[IDX_W-1:0];
  assign o_scale_blk = out_q[IDX_W-1:0] >> BLK_SH;

endmodule

// File: tb/tb_attention_fp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_attention_fp_ctrl
//   Directed bench for attention_fp_ctrl with S_KV=4, K=2, MM1_LAT=MM2_LAT=3.
//   A softmax model returns one result two cycles after every accepted
//   column. Accepted columns are pushed onto an expected-capture queue and
//   popped when the DUT raises o_cap_en.
// ---------------------------------------------------------------------------
module tb_attention_fp_ctrl;

  localparam int S_KV    = 4;
  localparam int K       = 2;
  localparam int MM1_LAT = 3;
  localparam int MM2_LAT = 3;
  localparam int IDX_W   = 2;
  // Start cycle to done cycle with no backpressure and softmax latency 2.
  localparam int NOM_LAT = 13;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start;
  logic             i_abort;
  logic             o_busy;
  logic             o_mm1_en;
  logic [IDX_W-1:0] o_col_idx;
  logic             o_sm_valid;
  logic             i_sm_ready;
  logic             i_sm_out_valid;
  logic             o_cap_en;
  logic [IDX_W-1:0] o_cap_idx;
  logic [IDX_W-1:0] o_scale_blk;
  logic             o_mm2_en;
  logic             o_done;

  int         testsRun  = 0;
  int         failCount = 0;
  int         cycleNo   = 0;
  int         expCol;
  int         capQ[$];
  logic [1:0] smPipe;
  int         mm1Count, mm2Count, doneCount, capCount, doneCycle;
  int         startCycle;
  bit         aborted;

  always #5 i_clk = ~i_clk;

  attention_fp_ctrl #(
    .S_KV   (S_KV),
    .K      (K),
    .MM1_LAT(MM1_LAT),
    .MM2_LAT(MM2_LAT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .o_busy        (o_busy),
    .o_mm1_en      (o_mm1_en),
    .o_col_idx     (o_col_idx),
    .o_sm_valid    (o_sm_valid),
    .i_sm_ready    (i_sm_ready),
    .i_sm_out_valid(i_sm_out_valid),
    .o_cap_en      (o_cap_en),
    .o_cap_idx     (o_cap_idx),
    .o_scale_blk   (o_scale_blk),
    .o_mm2_en      (o_mm2_en),
    .o_done        (o_done)
  );

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearPass();
    expCol    = 0;
    capQ.delete();
    smPipe    = 2'b00;
    mm1Count  = 0;
    mm2Count  = 0;
    doneCount = 0;
    capCount  = 0;
    doneCycle = -1;
  endtask

  // Drives one cycle of inputs just after a rising edge, scores the outputs
  // of that cycle, then advances to just after the next rising edge.
  task automatic applyStimulus(input bit start, input bit abort, input bit ready, input bit extra);
    bit smIn;
    int expIdx;
    i_start        = start;
    i_abort        = abort;
    i_sm_ready     = ready;
    i_sm_out_valid = smPipe[1] | extra;
    #1;
    smIn = 1'b0;
    if (o_sm_valid) begin
      checkOutput("col_idx", o_col_idx, expCol);
      if (ready) begin
        capQ.push_back(expCol);
        expCol++;
        smIn = 1'b1;
      end
    end
    if (extra) checkOutput("excess_cap_en", o_cap_en, 0);
    if (o_cap_en) begin
      capCount++;
      if (capQ.size() != 0) begin
        expIdx = capQ.pop_front();
        checkOutput("cap_idx", o_cap_idx, expIdx);
        checkOutput("scale_blk", o_scale_blk, expIdx / K);
      end
    end
    if (o_mm1_en) mm1Count++;
    if (o_mm2_en) mm2Count++;
    if (o_done) begin
      doneCount++;
      doneCycle = cycleNo;
    end
    smPipe = {smPipe[0], smIn};
    cycleNo++;
    @(posedge i_clk);
    #1;
  endtask

  // Runs one pass from IDLE. Optional: stall a column, abort or inject a
  // stray softmax valid on the first MM2 cycle, keep i_start high throughout.
  task automatic runPass(input int stallCol, input int stallLen, input bit abortMm2,
                         input bit extraMm2, input bit holdStart,
                         output int passStart, output bit passAborted);
    int stallLeft;
    bit mm2Seen, ab, ex, rdy;
    clearPass();
    passStart   = cycleNo;
    stallLeft   = stallLen;
    mm2Seen     = 1'b0;
    passAborted = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 80; c++) begin
      if (doneCount != 0 || passAborted) break;
      rdy = 1'b1;
      ab  = 1'b0;
      ex  = 1'b0;
      if (o_sm_valid && expCol == stallCol && stallLeft > 0) begin
        rdy = 1'b0;
        stallLeft--;
      end
      if (o_mm2_en && !mm2Seen) begin
        mm2Seen     = 1'b1;
        ab          = abortMm2;
        ex          = extraMm2;
        passAborted = abortMm2;
      end
      applyStimulus(holdStart, ab, rdy, ex);
    end
    if (!passAborted) checkOutput("done_seen", doneCount, 1);
  endtask

  task automatic checkCleanPass(input string name, input int extraLat);
    checkOutput({name, "_mm1_cycles"}, mm1Count, MM1_LAT);
    checkOutput({name, "_mm2_cycles"}, mm2Count, MM2_LAT);
    checkOutput({name, "_cols_fed"}, expCol, S_KV);
    checkOutput({name, "_caps"}, capCount, S_KV);
    checkOutput({name, "_capq_left"}, capQ.size(), 0);
    checkOutput({name, "_latency"}, doneCycle - startCycle, NOM_LAT + extraLat);
  endtask

  initial begin
    i_rst_n        = 1'b1;
    i_start        = 1'b0;
    i_abort        = 1'b0;
    i_sm_ready     = 1'b0;
    i_sm_out_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #10;
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_mm1_en", o_mm1_en, 0);
    checkOutput("rst_sm_valid", o_sm_valid, 0);
    checkOutput("rst_col_idx", o_col_idx, 0);
    checkOutput("rst_cap_en", o_cap_en, 0);
    checkOutput("rst_cap_idx", o_cap_idx, 0);
    checkOutput("rst_scale_blk", o_scale_blk, 0);
    checkOutput("rst_mm2_en", o_mm2_en, 0);
    checkOutput("rst_done", o_done, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    clearPass();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_busy", o_busy, 0);

    $display("[TB] nominal pass with overlap and excess softmax valid");
    runPass(-1, 0, 1'b0, 1'b1, 1'b0, startCycle, aborted);
    checkCleanPass("nominal", 0);
    checkOutput("nominal_idle_after", o_busy, 0);

    $display("[TB] backpressure on column 2 for 5 cycles");
    runPass(2, 5, 1'b0, 1'b0, 1'b0, startCycle, aborted);
    checkCleanPass("bp", 5);

    $display("[TB] abort in MM2");
    runPass(-1, 0, 1'b1, 1'b0, 1'b0, startCycle, aborted);
    checkOutput("abort_taken", aborted, 1);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_mm2_en", o_mm2_en, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_no_done", doneCount, 0);
    checkOutput("abort_still_idle", o_busy, 0);
    runPass(-1, 0, 1'b0, 1'b0, 1'b0, startCycle, aborted);
    checkCleanPass("post_abort", 0);

    $display("[TB] i_start held high across two passes");
    runPass(-1, 0, 1'b0, 1'b0, 1'b1, startCycle, aborted);
    checkCleanPass("hold1", 0);
    checkOutput("hold_gap_busy", o_busy, 0);
    runPass(-1, 0, 1'b0, 1'b0, 1'b1, startCycle, aborted);
    checkCleanPass("hold2", 0);

    $display("[TB] reset asserted mid-FEED");
    clearPass();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 20 && expCol < 2; c++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset_sm_valid", o_sm_valid, 1);
    checkOutput("pre_reset_col_idx", o_col_idx, 2);
    i_sm_out_valid = 1'b1;
    i_rst_n        = 1'b0;
    #1;
    checkOutput("midrst_busy", o_busy, 0);
    checkOutput("midrst_mm1_en", o_mm1_en, 0);
    checkOutput("midrst_sm_valid", o_sm_valid, 0);
    checkOutput("midrst_col_idx", o_col_idx, 0);
    checkOutput("midrst_cap_en", o_cap_en, 0);
    checkOutput("midrst_cap_idx", o_cap_idx, 0);
    checkOutput("midrst_scale_blk", o_scale_blk, 0);
    checkOutput("midrst_mm2_en", o_mm2_en, 0);
    checkOutput("midrst_done", o_done, 0);
    i_sm_out_valid = 1'b0;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    clearPass();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("postrst_busy", o_busy, 0);
    checkOutput("postrst_sm_valid", o_sm_valid, 0);
    runPass(-1, 0, 1'b0, 1'b0, 1'b0, startCycle, aborted);
    checkCleanPass("post_reset", 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
